bsg_zynq_fifo_pkt_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that merges num_src_p PS-to-PL FIFO streams into one PL-to-PS FIFO stream.
- Sits between the bsg_zynq_pl_shell FIFO ports of one or more AXI shells, replacing hard-wired cross-connect loopbacks.
- Each packet is one header word followed by len payload words. A grant is held for the whole packet so packets never interleave.

---
 rtl/bsg_zynq_fifo_pkt_arbiter.sv | 136 +++++++++++++
 tb/tb_bsg_zynq_fifo_pkt_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_zynq_fifo_pkt_arbiter.sv
// Packet-aware round-robin merge of PS-to-PL FIFO streams into one PL-to-PS stream.
// Define BSG_ZYNQ_ARB_TAG_EN to stamp the granted source id into header MSBs.
module bsg_zynq_fifo_pkt_arbiter #(
  parameter int num_src_p    = 2,
  parameter int data_width_p = 32,
  parameter int len_width_p  = 8,
  parameter int id_width_p   = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*data_width_p-1:0] data_i,
  input  logic [num_src_p-1:0]              v_i,
  output logic [num_src_p-1:0]              yumi_o,
  output logic [data_width_p-1:0]           data_o,
  output logic                              v_o,
  input  logic                              ready_i,
  input  logic [num_src_p-1:0]              en_mask_i,
  output logic                              busy_o,
  output logic [id_width_p-1:0]             grant_id_o,
  output logic [31:0]                       pkt_count_o
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                  state_q, state_n;
  logic [id_width_p-1:0]   last_q, last_n;
  logic [id_width_p-1:0]   lock_q, lock_n;
  logic [len_width_p-1:0]  rem_q, rem_n;
  logic [31:0]             cnt_q, cnt_n;

  logic [num_src_p-1:0]    cand;
  logic                    arb_found;
  logic [id_width_p-1:0]   arb_sel;
  logic [id_width_p-1:0]   sel;
  logic [data_width_p-1:0] word;
  logic [len_width_p-1:0]  len;
  logic                    hs;

  assign cand = v_i & en_mask_i;

  // Search starts just after the last completed grant and wraps.
  always_comb begin : rr
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int i = 1; i <= num_src_p; i++) begin
      j = (int'(last_q) + i) % num_src_p;
      if (!arb_found && cand[j]) begin
        arb_found = 1'b1;
        arb_sel   = id_width_p'(j);
      end
    end
  end

  assign sel  = (state_q == BURST) ? lock_q : arb_sel;
  assign word = data_i[sel*data_width_p +: data_width_p];
  assign len  = word[len_width_p-1:0];

  always_comb begin
    v_o    = 1'b0;
    data_o = '0;
    if (state_q == BURST) begin
      v_o    = v_i[lock_q];
      data_o = word;
    end else if (arb_found) begin
      v_o    = 1'b1;
      data_o = word;
`ifdef BSG_ZYNQ_ARB_TAG_EN
      data_o[data_width_p-1 -: id_width_p] = sel;
`endif
    end
  end

  assign hs = v_o & ready_i;

  always_comb begin
    for (int k = 0; k < num_src_p; k++) begin
      yumi_o[k] = hs && (sel == id_width_p'(k));
    end
  end

  always_comb begin
    state_n = state_q;
    last_n  = last_q;
    lock_n  = lock_q;
    rem_n   = rem_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (len == '0) begin
            last_n = sel;
            cnt_n  = cnt_q + 32'd1;
          end else begin
            rem_n   = len;
            lock_n  = sel;
            state_n = BURST;
          end
        end
      end
      BURST: begin
        if (hs) begin
          rem_n = rem_q - 1'b1;
          if (rem_q == len_width_p'(1)) begin
            state_n = IDLE;
            last_n  = lock_q;
            cnt_n   = cnt_q + 32'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= id_width_p'(num_src_p - 1);
      lock_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      last_q  <= last_n;
      lock_q  <= lock_n;
      rem_q   <= rem_n;
      cnt_q   <= cnt_n;
    end
  end

  assign busy_o      = (state_q == BURST);
  assign grant_id_o  = (state_q == BURST) ? lock_q : last_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: tb/tb_bsg_zynq_fifo_pkt_arbiter.sv
// Randomized scoreboard bench for bsg_zynq_fifo_pkt_arbiter.
// Packet-level reference model; honours BSG_ZYNQ_ARB_TAG_EN if defined.
module tb_bsg_zynq_fifo_pkt_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    v_i;
  logic [N-1:0]    yumi_o;
  logic [DW-1:0]   data_o;
  logic            v_o;
  logic            ready_i;
  logic [N-1:0]    en_mask_i;
  logic            busy_o;
  logic [IW-1:0]   grant_id_o;
  logic [31:0]     pkt_count_o;

  bsg_zynq_fifo_pkt_arbiter #(
    .num_src_p(N), .data_width_p(DW), .len_width_p(LW), .id_width_p(IW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
    .yumi_o(yumi_o), .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
    .en_mask_i(en_mask_i), .busy_o(busy_o), .grant_id_o(grant_id_o),
    .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  yumi;
  } xfer_t;

  typedef struct {
    logic          v;
    logic          busy;
    logic [IW-1:0] grant;
    logic [31:0]   cnt;
    logic          zero;
  } stat_t;

  xfer_t         exp_q[$];
  stat_t         stat_q[$];
  logic [DW-1:0] src_q[N][$];

  bit          m_busy;
  int          m_last, m_lock, m_rem;
  logic [31:0] m_cnt;
  int          checks = 0;
  int          failures = 0;

  task automatic gen_pkt(int s);
    logic [DW-1:0] h;
    int len;
    len = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 5);
    h = $urandom;
    h[LW-1:0] = LW'(len);
    src_q[s].push_back(h);
    for (int k = 0; k < len; k++) src_q[s].push_back($urandom);
  endtask

  task automatic model_reset();
    if (m_busy) begin
      for (int k = 0; k < m_rem; k++) void'(src_q[m_lock].pop_front());
    end
    m_busy = 0;
    m_last = N - 1;
    m_lock = 0;
    m_rem  = 0;
    m_cnt  = '0;
  endtask

  task automatic model_step();
    stat_t st;
    xfer_t x;
    logic [DW-1:0] w;
    int sel;
    bit v;
    sel = -1;
    st.busy  = m_busy;
    st.grant = m_busy ? IW'(m_lock) : IW'(m_last);
    st.cnt   = m_cnt;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (sel < 0 && v_i[c] && en_mask_i[c]) sel = c;
      end
      v = (sel >= 0);
    end else begin
      sel = m_lock;
      v = v_i[m_lock];
    end
    st.v = v;
    st.zero = !m_busy && !v;
    stat_q.push_back(st);
    if (v && ready_i) begin
      w = src_q[sel].pop_front();
      x.data = w;
`ifdef BSG_ZYNQ_ARB_TAG_EN
      if (!m_busy) x.data[DW-1 -: IW] = IW'(sel);
`endif
      x.yumi = N'(1) << sel;
      exp_q.push_back(x);
      if (!m_busy) begin
        if (w[LW-1:0] == '0) begin
          m_last = sel;
          m_cnt  = m_cnt + 1;
        end else begin
          m_rem  = int'(w[LW-1:0]);
          m_lock = sel;
          m_busy = 1;
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0;
          m_last = m_lock;
          m_cnt  = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic cycle(bit bubbles, bit rnd_ready, bit rnd_mask);
    @(negedge clk);
    reset_i = 1'b0;
    for (int s = 0; s < N; s++) begin
      v_i[s] = (src_q[s].size() > 0) && (!bubbles || $urandom_range(0, 3) != 0);
      data_i[s*DW +: DW] = (src_q[s].size() > 0) ? src_q[s][0] : DW'($urandom);
    end
    ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    en_mask_i = '1;
    if (rnd_mask && $urandom_range(0, 5) == 0) en_mask_i = N'($urandom);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i   = 1'b1;
    v_i       = '0;
    ready_i   = 1'b1;
    en_mask_i = '1;
    model_reset();
  endtask

  // Monitor: compares DUT outputs against queued expectations each cycle.
  initial begin
    stat_t st;
    xfer_t x;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_i && stat_q.size() > 0) begin
        st = stat_q.pop_front();
        checks++;
        if (v_o !== st.v || busy_o !== st.busy || grant_id_o !== st.grant ||
            pkt_count_o !== st.cnt || (st.zero && data_o !== '0)) begin
          failures++;
          $display("FAIL status: got v=%b busy=%b grant=%0d cnt=%0d data=%h want v=%b busy=%b grant=%0d cnt=%0d zero=%b",
                   v_o, busy_o, grant_id_o, pkt_count_o, data_o,
                   st.v, st.busy, st.grant, st.cnt, st.zero);
        end
        if (v_o && ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL xfer: got data=%h yumi=%b want no transfer", data_o, yumi_o);
          end else begin
            x = exp_q.pop_front();
            if (data_o !== x.data || yumi_o !== x.yumi) begin
              failures++;
              $display("FAIL xfer: got data=%h yumi=%b want data=%h yumi=%b",
                       data_o, yumi_o, x.data, x.yumi);
            end
          end
        end else if (yumi_o !== '0) begin
          checks++;
          failures++;
          $display("FAIL yumi: got %b want 0 (no handshake)", yumi_o);
        end
      end
    end
  end

  initial begin
    bit rst_done;
    int guard;
    rst_done  = 0;
    reset_i   = 1'b1;
    v_i       = '0;
    data_i    = '0;
    ready_i   = 1'b1;
    en_mask_i = '1;
    m_busy    = 0;
    m_rem     = 0;
    model_reset();
    do_reset();
    do_reset();
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 4; p++) gen_pkt(s);
    // Full-rate phase exercises plain round-robin alternation.
    repeat (20) cycle(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if (i >= 250 && !rst_done && m_busy && m_rem > 1) begin
        do_reset();
        rst_done = 1;
      end else begin
        cycle(1, 1, 1);
      end
      for (int s = 0; s < N; s++)
        if (i < 450 && src_q[s].size() < 3 && $urandom_range(0, 2) == 0) gen_pkt(s);
    end
    guard = 0;
    while ((m_busy || src_q[0].size() > 0 || src_q[1].size() > 0 ||
            src_q[2].size() > 0) && guard < 3000) begin
      cycle(0, 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 3000) begin
      failures++;
      $display("FAIL drain: sources not drained after %0d cycles", guard);
    end
    repeat (3) cycle(0, 0, 0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending transfers want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
